// File: rtl/uart_rx_cfg_if.sv
// Byte-stream side of the configurable UART receiver: serial line, frame mode,
// divisor and the per-frame result with its flags.
interface uart_rx_cfg_if #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned CNT_W     = 16
);

    // Line and mode inputs, driven by the pin/config owner
    logic                 i_RX_Serial;
    logic [CNT_W-1:0]     i_Clks_Per_Bit;
    logic                 i_Parity_En;
    logic                 i_Parity_Odd;
    logic                 i_Two_Stop;

    // Frame results, driven by the receiver
    logic                 o_RX_DV;
    logic [DATA_BITS-1:0] o_RX_Data;
    logic                 o_Parity_Err;
    logic                 o_Frame_Err;
    logic                 o_Break;
    logic                 o_Busy;

    // Side that owns the line and the configuration
    modport master (
        output i_RX_Serial,
        output i_Clks_Per_Bit,
        output i_Parity_En,
        output i_Parity_Odd,
        output i_Two_Stop,
        input  o_RX_DV,
        input  o_RX_Data,
        input  o_Parity_Err,
        input  o_Frame_Err,
        input  o_Break,
        input  o_Busy
    );

    // Receiver side
    modport slave (
        input  i_RX_Serial,
        input  i_Clks_Per_Bit,
        input  i_Parity_En,
        input  i_Parity_Odd,
        input  i_Two_Stop,
        output o_RX_DV,
        output o_RX_Data,
        output o_Parity_Err,
        output o_Frame_Err,
        output o_Break,
        output o_Busy
    );

endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, optional even/odd parity, one or
// two stop bits, runtime baud divisor. Line is synchronised, start bits are
// re-checked at mid-bit to reject glitches, and parity/framing/break flags are
// reported alongside each received word.
module uart_rx_cfg #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic          i_Clock,
    input logic          i_Rst,
    uart_rx_cfg_if.slave bus
);

    localparam int unsigned IDX_W = 4;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBrkWait
    } state_e;

    // Elaboration-time parameter checks
    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : gen_bad_data_bits
        $error("uart_rx_cfg: DATA_BITS must be in the range 5..9");
    end
    if (SYNC_STAGES < 2) begin : gen_bad_sync_stages
        $error("uart_rx_cfg: SYNC_STAGES must be at least 2");
    end

    // Synchroniser
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    // FSM and datapath state
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_bit_q, par_bit_d;
    logic                   ferr_q, ferr_d;
    logic                   stop_idx_q, stop_idx_d;

    // Mode captured at the start of each frame
    logic [CNT_W-1:0]       div_q, div_d;
    logic                   par_en_q, par_en_d;
    logic                   par_odd_q, par_odd_d;
    logic                   two_stop_q, two_stop_d;

    // Registered frame results
    logic                   rx_dv_q, rx_dv_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   perr_q, perr_d;
    logic                   frame_err_q, frame_err_d;
    logic                   break_q, break_d;

    // Helper terms
    logic                   bit_end;
    logic                   stop_ferr;
    logic                   perr_calc;
    logic                   brk_calc;

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Line synchroniser; presets to idle-high so reset never looks like a start bit
    always_ff @(posedge i_Clock or posedge i_Rst) begin
        if (i_Rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.i_RX_Serial};
        end
    end

    // Next-state, sampling and result capture
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        par_bit_d   = par_bit_q;
        ferr_d      = ferr_q;
        stop_idx_d  = stop_idx_q;
        div_d       = div_q;
        par_en_d    = par_en_q;
        par_odd_d   = par_odd_q;
        two_stop_d  = two_stop_q;
        rx_dv_d     = 1'b0;
        rx_data_d   = rx_data_q;
        perr_d      = perr_q;
        frame_err_d = frame_err_q;
        break_d     = break_q;

        bit_end   = (cnt_q == (div_q - CNT_W'(1)));
        // A low stop sample in either stop slot makes the frame bad
        stop_ferr = ferr_q | ~rx_s;
        perr_calc = ((^shift_q) ^ par_bit_q) != par_odd_q;
        brk_calc  = stop_ferr && (shift_q == '0) && (!par_en_q || !par_bit_q);

        unique case (state_q)
            StIdle: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (!rx_s) begin
                    state_d    = StStart;
                    div_d      = bus.i_Clks_Per_Bit;
                    par_en_d   = bus.i_Parity_En;
                    par_odd_d  = bus.i_Parity_Odd;
                    two_stop_d = bus.i_Two_Stop;
                    par_bit_d  = 1'b0;
                    ferr_d     = 1'b0;
                    stop_idx_d = 1'b0;
                end
            end

            StStart: begin
                // Re-check the line at mid start bit; a high here was a glitch
                if (cnt_q == (div_q >> 1)) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = StData;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            StData: begin
                if (bit_end) begin
                    // LSB arrives first, so shift in from the top
                    shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                    cnt_d     = '0;
                    bit_idx_d = bit_idx_q + IDX_W'(1);
                    if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
                        state_d = par_en_q ? StParity : StStop;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            StParity: begin
                if (bit_end) begin
                    par_bit_d = rx_s;
                    cnt_d     = '0;
                    state_d   = StStop;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            StStop: begin
                if (bit_end) begin
                    cnt_d  = '0;
                    ferr_d = stop_ferr;
                    if (two_stop_q && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                    end else begin
                        rx_dv_d     = 1'b1;
                        rx_data_d   = shift_q;
                        perr_d      = par_en_q & perr_calc;
                        frame_err_d = stop_ferr;
                        break_d     = brk_calc;
                        // A bad stop may be a held-low line; wait for idle before re-arming
                        state_d     = stop_ferr ? StBrkWait : StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            StBrkWait: begin
                if (rx_s) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and result registers
    always_ff @(posedge i_Clock or posedge i_Rst) begin
        if (i_Rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            par_bit_q   <= 1'b0;
            ferr_q      <= 1'b0;
            stop_idx_q  <= 1'b0;
            div_q       <= '0;
            par_en_q    <= 1'b0;
            par_odd_q   <= 1'b0;
            two_stop_q  <= 1'b0;
            rx_dv_q     <= 1'b0;
            rx_data_q   <= '0;
            perr_q      <= 1'b0;
            frame_err_q <= 1'b0;
            break_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            par_bit_q   <= par_bit_d;
            ferr_q      <= ferr_d;
            stop_idx_q  <= stop_idx_d;
            div_q       <= div_d;
            par_en_q    <= par_en_d;
            par_odd_q   <= par_odd_d;
            two_stop_q  <= two_stop_d;
            rx_dv_q     <= rx_dv_d;
            rx_data_q   <= rx_data_d;
            perr_q      <= perr_d;
            frame_err_q <= frame_err_d;
            break_q     <= break_d;
        end
    end

    assign bus.o_RX_DV      = rx_dv_q;
    assign bus.o_RX_Data    = rx_data_q;
    assign bus.o_Parity_Err = perr_q;
    assign bus.o_Frame_Err  = frame_err_q;
    assign bus.o_Break      = break_q;
    assign bus.o_Busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: table of directed frames, randomized frames checked
// against a frame-level reference model, and hand sequences for glitch, break,
// mode latching, mid-frame reset and the 5/9-bit variants.
module tb_uart_rx_cfg;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned SYNC  = 2;
    localparam int          TOL   = SYNC + 2;

    typedef struct {
        logic [8:0] data;
        int         nbits;
        int         div;
        bit         par_en;
        bit         par_odd;
        bit         par_bit;
        bit         stop1;
        bit         stop2;
        bit         two_stop;
    } frame_t;

    typedef struct {
        logic [8:0] data;
        bit         perr;
        bit         ferr;
        bit         brk;
    } exp_t;

    typedef struct {
        frame_t f;
        exp_t   e;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       line;
    logic [CNT_W-1:0] cpb;
    logic             par_en;
    logic             par_odd;
    logic             two_stop;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint cyc      = 0;
    longint fall_cyc = 0;

    int         dv_cnt  [3] = '{0, 0, 0};
    logic [8:0] dv_data [3];
    logic       dv_perr [3];
    logic       dv_ferr [3];
    logic       dv_brk  [3];
    longint     dv_cyc  [3];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_cfg_if #(.DATA_BITS(8), .CNT_W(CNT_W)) bus8 ();
    uart_rx_cfg_if #(.DATA_BITS(5), .CNT_W(CNT_W)) bus5 ();
    uart_rx_cfg_if #(.DATA_BITS(9), .CNT_W(CNT_W)) bus9 ();

    assign bus8.i_RX_Serial    = line[0];
    assign bus5.i_RX_Serial    = line[1];
    assign bus9.i_RX_Serial    = line[2];
    assign bus8.i_Clks_Per_Bit = cpb;
    assign bus5.i_Clks_Per_Bit = cpb;
    assign bus9.i_Clks_Per_Bit = cpb;
    assign bus8.i_Parity_En    = par_en;
    assign bus5.i_Parity_En    = par_en;
    assign bus9.i_Parity_En    = par_en;
    assign bus8.i_Parity_Odd   = par_odd;
    assign bus5.i_Parity_Odd   = par_odd;
    assign bus9.i_Parity_Odd   = par_odd;
    assign bus8.i_Two_Stop     = two_stop;
    assign bus5.i_Two_Stop     = two_stop;
    assign bus9.i_Two_Stop     = two_stop;

    uart_rx_cfg #(.DATA_BITS(8), .CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut8 (
        .i_Clock (clk),
        .i_Rst   (rst),
        .bus     (bus8)
    );
    uart_rx_cfg #(.DATA_BITS(5), .CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut5 (
        .i_Clock (clk),
        .i_Rst   (rst),
        .bus     (bus5)
    );
    uart_rx_cfg #(.DATA_BITS(9), .CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut9 (
        .i_Clock (clk),
        .i_Rst   (rst),
        .bus     (bus9)
    );

    // DV monitors, sampled on the falling edge
    always @(negedge clk) begin
        if (bus8.o_RX_DV === 1'b1) begin
            dv_cnt[0]  <= dv_cnt[0] + 1;
            dv_data[0] <= {1'b0, bus8.o_RX_Data};
            dv_perr[0] <= bus8.o_Parity_Err;
            dv_ferr[0] <= bus8.o_Frame_Err;
            dv_brk[0]  <= bus8.o_Break;
            dv_cyc[0]  <= cyc;
        end
    end
    always @(negedge clk) begin
        if (bus5.o_RX_DV === 1'b1) begin
            dv_cnt[1]  <= dv_cnt[1] + 1;
            dv_data[1] <= {4'b0, bus5.o_RX_Data};
            dv_perr[1] <= bus5.o_Parity_Err;
            dv_ferr[1] <= bus5.o_Frame_Err;
            dv_brk[1]  <= bus5.o_Break;
            dv_cyc[1]  <= cyc;
        end
    end
    always @(negedge clk) begin
        if (bus9.o_RX_DV === 1'b1) begin
            dv_cnt[2]  <= dv_cnt[2] + 1;
            dv_data[2] <= bus9.o_RX_Data;
            dv_perr[2] <= bus9.o_Parity_Err;
            dv_ferr[2] <= bus9.o_Frame_Err;
            dv_brk[2]  <= bus9.o_Break;
            dv_cyc[2]  <= cyc;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, actual still running, required finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic set_line(input int which, input logic v);
        line[which] = v;
    endtask

    function automatic logic get_busy(input int which);
        case (which)
            0:       return bus8.o_Busy;
            1:       return bus5.o_Busy;
            default: return bus9.o_Busy;
        endcase
    endfunction

    // Frame-level reference: parity by population count, flags by definition
    function automatic exp_t model(input frame_t f);
        exp_t       e;
        logic [8:0] mask;
        mask   = 9'((1 << f.nbits) - 1);
        e.data = f.data & mask;
        e.perr = f.par_en && ((($countones(e.data) + int'(f.par_bit)) % 2) != int'(f.par_odd));
        e.ferr = !f.stop1 || (f.two_stop && !f.stop2);
        e.brk  = e.ferr && (e.data == 9'd0) && (!f.par_en || !f.par_bit);
        return e;
    endfunction

    task automatic send_frame(input int which, input frame_t f, input bit mid_change);
        cpb      = CNT_W'(f.div);
        par_en   = f.par_en;
        par_odd  = f.par_odd;
        two_stop = f.two_stop;
        @(negedge clk);
        set_line(which, 1'b0);
        fall_cyc = cyc;
        repeat (f.div) @(negedge clk);
        if (mid_change) begin
            cpb      = CNT_W'(8);
            two_stop = ~two_stop;
        end
        for (int i = 0; i < f.nbits; i++) begin
            set_line(which, f.data[i]);
            repeat (f.div) @(negedge clk);
        end
        if (f.par_en) begin
            set_line(which, f.par_bit);
            repeat (f.div) @(negedge clk);
        end
        set_line(which, f.stop1);
        repeat (f.div) @(negedge clk);
        if (f.two_stop) begin
            set_line(which, f.stop2);
            repeat (f.div) @(negedge clk);
        end
        set_line(which, 1'b1);
        repeat (2 * f.div + 10) @(negedge clk);
    endtask

    task automatic run_frame(input int which, input frame_t f, input exp_t e, input string tag,
                             input bit mid_change);
        int     c0;
        int     k;
        longint ideal;
        longint lat;
        c0 = dv_cnt[which];
        send_frame(which, f, mid_change);
        check($sformatf("%s.dv_count", tag), dv_cnt[which] - c0, 1);
        check($sformatf("%s.data", tag), dv_data[which], e.data);
        check($sformatf("%s.perr", tag), dv_perr[which], e.perr);
        check($sformatf("%s.ferr", tag), dv_ferr[which], e.ferr);
        check($sformatf("%s.break", tag), dv_brk[which], e.brk);
        check($sformatf("%s.busy_after", tag), get_busy(which), 0);
        k     = f.nbits + int'(f.par_en) + 1 + int'(f.two_stop);
        ideal = (longint'(f.div) * (2 * k + 1) + 1) / 2;
        lat   = dv_cyc[which] - fall_cyc;
        n_checks++;
        if ((dv_cnt[which] == c0) || (lat < ideal - TOL) || (lat > ideal + TOL)) begin
            n_fail++;
            $display("FAIL %s.latency: actual %0d clocks, required %0d +/- %0d",
                     tag, lat, ideal, TOL);
        end
    endtask

    initial begin
        vec_t   tbl [10];
        frame_t f;
        exp_t   e;
        int     c0;

        //           data    nb div pen odd pb s1 s2 two     data    pe fe bk
        tbl[0] = '{'{9'h0A5, 8, 16, 0, 0, 0, 1, 1, 0}, '{9'h0A5, 0, 0, 0}};
        tbl[1] = '{'{9'h03C, 8, 10, 1, 0, 0, 1, 1, 0}, '{9'h03C, 0, 0, 0}};
        tbl[2] = '{'{9'h03C, 8, 10, 1, 0, 1, 1, 1, 0}, '{9'h03C, 1, 0, 0}};
        tbl[3] = '{'{9'h03C, 8, 10, 1, 1, 1, 1, 1, 0}, '{9'h03C, 0, 0, 0}};
        tbl[4] = '{'{9'h055, 8, 16, 0, 0, 0, 0, 1, 0}, '{9'h055, 0, 1, 0}};
        tbl[5] = '{'{9'h000, 8,  8, 0, 0, 0, 0, 1, 0}, '{9'h000, 0, 1, 1}};
        tbl[6] = '{'{9'h000, 8,  8, 1, 0, 1, 0, 1, 0}, '{9'h000, 1, 1, 0}};
        tbl[7] = '{'{9'h081, 8, 12, 0, 0, 0, 1, 1, 1}, '{9'h081, 0, 0, 0}};
        tbl[8] = '{'{9'h0FF, 8,  7, 1, 1, 1, 1, 0, 1}, '{9'h0FF, 0, 1, 0}};
        tbl[9] = '{'{9'h0C3, 8,  5, 1, 0, 0, 1, 1, 0}, '{9'h0C3, 0, 0, 0}};

        rst      = 1'b1;
        line     = 3'b111;
        cpb      = CNT_W'(16);
        par_en   = 1'b0;
        par_odd  = 1'b0;
        two_stop = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.outputs",
              {bus8.o_RX_DV, bus8.o_RX_Data, bus8.o_Parity_Err, bus8.o_Frame_Err,
               bus8.o_Break, bus8.o_Busy}, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("reset.no_dv", dv_cnt[0], 0);
        check("reset.busy", bus8.o_Busy, 0);

        for (int i = 0; i < 10; i++) begin
            run_frame(0, tbl[i].f, tbl[i].e, $sformatf("vec%0d", i), 1'b0);
        end

        // Glitch shorter than half a bit: busy briefly, never a DV
        cpb = CNT_W'(16);
        c0  = dv_cnt[0];
        @(negedge clk);
        set_line(0, 1'b0);
        repeat (5) @(negedge clk);
        check("glitch.busy_during", bus8.o_Busy, 1);
        @(negedge clk);
        set_line(0, 1'b1);
        repeat (40) @(negedge clk);
        check("glitch.no_dv", dv_cnt[0] - c0, 0);
        check("glitch.busy_after", bus8.o_Busy, 0);

        // Divisor and stop-count changes after the start bit must be ignored
        f = '{9'h05A, 8, 16, 0, 0, 0, 1, 1, 0};
        run_frame(0, f, model(f), "latch", 1'b1);

        // Line held low for 30 bit times: one break report only
        cpb      = CNT_W'(8);
        par_en   = 1'b0;
        two_stop = 1'b0;
        c0       = dv_cnt[0];
        @(negedge clk);
        set_line(0, 1'b0);
        repeat (240) @(negedge clk);
        set_line(0, 1'b1);
        repeat (40) @(negedge clk);
        check("break.dv_count", dv_cnt[0] - c0, 1);
        check("break.data", dv_data[0], 0);
        check("break.ferr", dv_ferr[0], 1);
        check("break.break", dv_brk[0], 1);
        check("break.busy_after", bus8.o_Busy, 0);
        f = '{9'h081, 8, 8, 0, 0, 0, 1, 1, 0};
        run_frame(0, f, '{9'h081, 0, 0, 0}, "after_break", 1'b0);

        // Reset in the middle of data bit 3
        cpb = CNT_W'(16);
        c0  = dv_cnt[0];
        @(negedge clk);
        set_line(0, 1'b0);
        repeat (16) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            set_line(0, 1'b1);
            repeat (16) @(negedge clk);
        end
        set_line(0, 1'b0);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midreset.outputs",
              {bus8.o_RX_DV, bus8.o_RX_Data, bus8.o_Parity_Err, bus8.o_Frame_Err,
               bus8.o_Break, bus8.o_Busy}, 0);
        set_line(0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        check("midreset.no_dv", dv_cnt[0] - c0, 0);
        check("midreset.busy", bus8.o_Busy, 0);
        f = '{9'h00F, 8, 16, 0, 0, 0, 1, 1, 0};
        run_frame(0, f, '{9'h00F, 0, 0, 0}, "post_reset", 1'b0);

        // Narrow and wide data variants with two stop bits
        f = '{9'h015, 5, 16, 0, 0, 0, 1, 1, 1};
        run_frame(1, f, '{9'h015, 0, 0, 0}, "bits5", 1'b0);
        f = '{9'h1A5, 9, 16, 0, 0, 0, 1, 1, 1};
        run_frame(2, f, '{9'h1A5, 0, 0, 0}, "bits9", 1'b0);

        // Randomized frames against the reference model
        for (int i = 0; i < 24; i++) begin
            f.data     = 9'($urandom_range(255, 0));
            if ($urandom_range(5, 0) == 0) f.data = 9'd0;
            f.nbits    = 8;
            f.div      = int'($urandom_range(20, 4));
            f.par_en   = 1'($urandom_range(1, 0));
            f.par_odd  = 1'($urandom_range(1, 0));
            f.par_bit  = 1'($urandom_range(1, 0));
            f.stop1    = ($urandom_range(7, 0) != 0);
            f.stop2    = ($urandom_range(7, 0) != 0);
            f.two_stop = 1'($urandom_range(1, 0));
            e          = model(f);
            run_frame(0, f, e, $sformatf("rand%0d", i), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
